// File: rtl/seq_divider_if.sv
// seq_divider_if: operand/result handshake bundle for the sequential divider.
//   master : operand producer and result consumer (drives in_valid, dividend, divisor, out_ready)
//   slave  : the divider (drives in_ready, out_valid, quotient, remainder, div_zero, busy)
interface seq_divider_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;
   logic             busy;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_zero, busy
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_zero, busy
   );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_divider_if.slave -- operand accept (in_valid/in_ready/dividend/divisor),
//           result presentation (out_valid/out_ready/quotient/remainder/div_zero), busy flag.
// A zero divisor skips the iteration and goes straight to DONE with quotient all ones
// and remainder equal to the dividend.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst_n,
   seq_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q,     state_d;
   logic [CW-1:0]    count_q,     count_d;
   logic [WIDTH-1:0] divisor_q,   divisor_d;
   logic [WIDTH-1:0] quo_q,       quo_d;
   logic [WIDTH-1:0] rem_q,       rem_d;
   logic [WIDTH-1:0] quotient_q,  quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             div_zero_q,  div_zero_d;

   // Partial remainder after the shift kept at WIDTH+1 bits: the bit shifted out of
   // rem_q must take part in the compare or large divisors give wrong results.
   logic [WIDTH:0]   shift_hi_s;
   logic [WIDTH:0]   diff_s;
   logic             ge_s;
   logic [WIDTH-1:0] rem_step_s;
   logic [WIDTH-1:0] quo_step_s;

   assign shift_hi_s = {rem_q, quo_q[WIDTH-1]};
   assign diff_s     = shift_hi_s - {1'b0, divisor_q};
   assign ge_s       = (shift_hi_s >= {1'b0, divisor_q});
   // diff_s < divisor whenever ge_s, so its low WIDTH bits hold the full value.
   assign rem_step_s = ge_s ? diff_s[WIDTH-1:0] : shift_hi_s[WIDTH-1:0];
   assign quo_step_s = {quo_q[WIDTH-2:0], ge_s};

   // Next-state and datapath update for the IDLE -> RUN -> DONE sequence
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      divisor_d   = divisor_q;
      quo_d       = quo_q;
      rem_d       = rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               divisor_d = bus.divisor;
               quo_d     = bus.dividend;
               rem_d     = {WIDTH{1'b0}};
               count_d   = {CW{1'b0}};
               if (bus.divisor == {WIDTH{1'b0}}) begin
                  state_d     = ST_DONE;
                  quotient_d  = {WIDTH{1'b1}};
                  remainder_d = bus.dividend;
                  div_zero_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            quo_d   = quo_step_s;
            rem_d   = rem_step_s;
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
               state_d     = ST_DONE;
               quotient_d  = quo_step_s;
               remainder_d = rem_step_s;
               div_zero_d  = 1'b0;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            // Operands presented here are ignored; only the drain handshake matters.
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         count_q     <= {CW{1'b0}};
         divisor_q   <= {WIDTH{1'b0}};
         quo_q       <= {WIDTH{1'b0}};
         rem_q       <= {WIDTH{1'b0}};
         quotient_q  <= {WIDTH{1'b0}};
         remainder_q <= {WIDTH{1'b0}};
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         divisor_q   <= divisor_d;
         quo_q       <= quo_d;
         rem_q       <= rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.busy      = (state_q == ST_RUN);
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.div_zero  = div_zero_q;
endmodule
